// File: rtl/pc_update_unit_pkg.sv
// Shared definitions for the PC update stage.
//   XLEN_DEFAULT      default datapath width for PC and branch offset
//   RESET_PC_DEFAULT  default PC loaded on reset
//   INSN_BYTES        fixed instruction width in bytes (no compressed ISA)
//   state_e           controller state encoding
package pc_update_unit_pkg;

    localparam int unsigned XLEN_DEFAULT     = 64;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_0000;
    localparam int unsigned INSN_BYTES       = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_e;

endpackage

// File: rtl/pc_update_unit_pc_adder.sv
// XLEN-bit modulo adder used for pc+4 and pc+offset.
//   a_i    first operand
//   b_i    second operand (two's complement values add naturally)
//   sum_o  a_i + b_i, carry discarded
module pc_adder #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/pc_update_unit.sv
// Program-counter stage: selects PC+4 or the branch target, registers it
// under the fetch handshake, traps on misaligned branch targets and counts
// retired instructions.
//   clk, reset      rising-edge clock, synchronous active-high reset
//   stall           hazard hold, PC does not advance
//   branch, zero    conditional branch and ALU zero flag -> taken
//   offset_shl      branch offset, already shifted left by one
//   fetch_ready     instruction memory accepts the current PC
//   pc              registered PC
//   pc_plus4        pc + 4 (combinational)
//   branch_target   pc + offset_shl (combinational)
//   taken           branch & zero (combinational)
//   fetch_valid     PC is valid for fetch
//   trap, trap_addr sticky misaligned-target flag and captured target
//   instret         count of PC advances since reset
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_BOOT | first cycle after reset, fetch held off for memory warm-up
// ST_RUN  | normal fetch, PC advances on accepted handshake
// ST_TRAP | misaligned target seen, everything frozen until reset
module pc_update_unit
    import pc_update_unit_pkg::*;
#(
    parameter int unsigned          XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]      RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch,
    input  logic            zero,
    input  logic [XLEN-1:0] offset_shl,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] branch_target,
    output logic            taken,
    output logic            fetch_valid,
    output logic            trap,
    output logic [XLEN-1:0] trap_addr,
    output logic [63:0]     instret
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] trap_addr_q, trap_addr_d;
    logic            trap_q, trap_d;
    logic [63:0]     instret_q, instret_d;

    pc_adder #(.W(XLEN)) u_add_plus4 (
        .a_i   (pc_q),
        .b_i   (XLEN'(INSN_BYTES)),
        .sum_o (pc_plus4)
    );

    pc_adder #(.W(XLEN)) u_add_target (
        .a_i   (pc_q),
        .b_i   (offset_shl),
        .sum_o (branch_target)
    );

    assign taken = branch & zero;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        trap_d      = trap_q;
        trap_addr_d = trap_addr_q;
        instret_d   = instret_q;
        fetch_valid = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                fetch_valid = 1'b1;
                // Alignment is only judged on an accepted fetch; a stalled
                // misaligned target may still be redirected before it retires.
                if (fetch_ready && !stall) begin
                    if (!taken) begin
                        pc_d      = pc_plus4;
                        instret_d = instret_q + 64'd1;
                    end else if (branch_target[1:0] == 2'b00) begin
                        pc_d      = branch_target;
                        instret_d = instret_q + 64'd1;
                    end else begin
                        trap_d      = 1'b1;
                        trap_addr_d = branch_target;
                        state_d     = ST_TRAP;
                    end
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
            instret_q   <= 64'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
            instret_q   <= instret_d;
        end
    end

    assign pc        = pc_q;
    assign trap      = trap_q;
    assign trap_addr = trap_addr_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_pc_update_unit.sv
module tb_pc_update_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic [63:0] offset_shl = '0;
    logic        fetch_ready = 1'b0;
    logic [63:0] pc, pc_plus4, branch_target, trap_addr, instret;
    logic        taken, fetch_valid, trap;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural view of the stage.
    logic [63:0] m_pc, m_instret, m_trap_addr;
    logic        m_booting, m_trapped;

    always #5 clk = ~clk;

    pc_update_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch        (branch),
        .zero          (zero),
        .offset_shl    (offset_shl),
        .fetch_ready   (fetch_ready),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .taken         (taken),
        .fetch_valid   (fetch_valid),
        .trap          (trap),
        .trap_addr     (trap_addr),
        .instret       (instret)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, s, rdy, br, z, input logic [63:0] off);
        logic [63:0] tgt;
        tgt = m_pc + off;
        if (r) begin
            m_pc = 64'd0; m_instret = 64'd0; m_trap_addr = 64'd0;
            m_booting = 1'b1; m_trapped = 1'b0;
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (!m_trapped && rdy && !s) begin
            if (!(br && z)) begin
                m_pc = m_pc + 64'd4;
                m_instret = m_instret + 64'd1;
            end else if (tgt % 4 == 0) begin
                m_pc = tgt;
                m_instret = m_instret + 64'd1;
            end else begin
                m_trapped = 1'b1;
                m_trap_addr = tgt;
            end
        end
    endtask

    task automatic step(input logic r, s, rdy, br, z, input logic [63:0] off);
        reset = r; stall = s; fetch_ready = rdy; branch = br; zero = z; offset_shl = off;
        model_update(r, s, rdy, br, z, off);
        @(posedge clk);
        #1;
        check("pc",            pc,            m_pc);
        check("pc_plus4",      pc_plus4,      m_pc + 64'd4);
        check("branch_target", branch_target, m_pc + off);
        check("taken",         64'(taken),    64'(br && z));
        check("fetch_valid",   64'(fetch_valid), 64'(!m_booting && !m_trapped));
        check("trap",          64'(trap),     64'(m_trapped));
        check("trap_addr",     trap_addr,     m_trap_addr);
        check("instret",       instret,       m_instret);
    endtask

    // Redirect to an aligned address via a taken branch.
    task automatic goto_pc(input logic [63:0] addr);
        step(0, 0, 1, 1, 1, addr - m_pc);
    endtask

    initial begin
        int trap_cycles;
        logic [63:0] off;
        logic [31:0] r32;

        m_pc = '0; m_instret = '0; m_trap_addr = '0; m_booting = 1'b1; m_trapped = 1'b0;
        #2;

        // Reset, boot, straight-line run
        step(1, 0, 1, 0, 0, 64'd0);
        step(0, 0, 1, 0, 0, 64'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 64'd0);
        check("instret_after_3", instret, 64'd3);
        check("pc_after_3", pc, 64'd12);

        // Taken and not-taken branch
        goto_pc(64'h100);
        step(0, 0, 1, 1, 1, 64'h20);
        check("taken_target", pc, 64'h120);
        goto_pc(64'h100);
        step(0, 0, 1, 1, 0, 64'h20);
        check("not_taken", pc, 64'h104);

        // Stall and not-ready hold
        goto_pc(64'h40);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 64'd0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 64'd0);
        check("hold_pc", pc, 64'h40);
        step(0, 0, 1, 0, 0, 64'd0);
        check("release_pc", pc, 64'h44);

        // Negative offset and wrap-around
        goto_pc(64'h10);
        step(0, 0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF0);
        check("neg_offset", pc, 64'h0);
        goto_pc(64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 1, 0, 0, 64'd0);
        check("wrap", pc, 64'h0);

        // Misaligned target, stalled first (no trap), then accepted
        goto_pc(64'h200);
        step(0, 1, 1, 1, 1, 64'h6);
        check("stalled_no_trap", 64'(trap), 64'd0);
        step(0, 0, 1, 1, 1, 64'h6);
        check("trap_set", 64'(trap), 64'd1);
        check("trap_addr_cap", trap_addr, 64'h206);
        check("trap_pc_hold", pc, 64'h200);
        for (int i = 0; i < 5; i++)
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom});
        check("trap_frozen_pc", pc, 64'h200);

        // Reset from TRAP while stalled
        step(1, 1, 1, 1, 1, 64'h6);
        check("rst_trap", 64'(trap), 64'd0);
        check("rst_instret", instret, 64'd0);
        step(0, 1, 1, 0, 0, 64'd0);

        // Randomized traffic
        trap_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            r32 = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: off = {{54{r32[9]}}, r32[9:0]} & ~64'h3;
                6, 7:             off = {$urandom, r32} & ~64'h3;
                8:                off = ({{54{r32[9]}}, r32[9:0]} & ~64'h3) | 64'h2;
                default:          off = {$urandom, r32} & ~64'h1;
            endcase
            trap_cycles = m_trapped ? trap_cycles + 1 : 0;
            step(($urandom_range(0, 49) == 0) || (trap_cycles > 6),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0,
                 1'($urandom), 1'($urandom), off);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Sequential program-counter stage that consumes the sign-extended, left-shifted branch offset produced by the shift-by-1 stage.
- Adds that offset to the current PC and selects between PC+4 and the branch target.
- Registers the result as the PC, gated by a fetch handshake and a stall input.
- Also checks target alignment (sticky trap) and counts retired instructions. Sits between the immediate/shift path and instruction memory.

Parameters:
- XLEN, 64, datapath width for PC and offset.
- RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard hold; when 1 the PC does not advance.
- branch  input  1  current instruction is a conditional branch (from control).
- zero  input  1  ALU zero flag for the current instruction.
- offset_shl  input  XLEN  branch offset already shifted left by 1.
- fetch_ready  input  1  instruction memory accepts the current PC.
- pc  output  XLEN  registered current PC.
- pc_plus4  output  XLEN  pc + 4, combinational.
- branch_target  output  XLEN  pc + offset_shl, combinational.
- taken  output  1  branch & zero, combinational.
- fetch_valid  output  1  PC is valid for fetch (state RUN).
- trap  output  1  sticky misaligned-target flag.
- trap_addr  output  XLEN  offending target captured at trap entry.
- instret  output  64  count of PC advances since reset.

Behaviour:
- Reset (synchronous, reset=1 at clk edge):
  - pc=RESET_PC, state=BOOT, trap=0, trap_addr=0, instret=0.
  - fetch_valid is 0 during reset and BOOT.
  - Reset overrides all other inputs in any state, including TRAP and mid-stall.
- State BOOT: one cycle with fetch_valid=0, then unconditionally RUN. Gives instruction memory one cycle after reset release.
- State RUN: fetch_valid=1.
  - advance = fetch_valid & fetch_ready & ~stall.
  - taken = branch & zero. next = taken ? branch_target : pc_plus4.
  - advance & ~taken: pc <= pc_plus4, instret++.
  - advance & taken & branch_target[1:0]==0: pc <= branch_target, instret++.
  - advance & taken & branch_target[1:0]!=0: pc holds, instret holds, trap <= 1, trap_addr <= branch_target, state <= TRAP.
  - No advance (stall=1 or fetch_ready=0): pc, instret, trap hold. The alignment check is not evaluated.
- State TRAP: fetch_valid=0, pc frozen, trap=1. All inputs ignored until reset.
- Arithmetic:
  - pc_plus4 and branch_target are XLEN-bit, modulo 2^XLEN; carry is discarded.
  - Wrap-around: pc=64'hFFFF_FFFF_FFFF_FFFC advancing gives pc=0.
  - offset_shl is treated as two's complement, so a negative offset is handled by the plain add.
- Alignment: only bits [1:0] are checked (no compressed ISA). The stage above guarantees bit 0 = 0, so bit 1 is the live check.
- instret wraps at 2^64 with no flag.
- Latency: pc updates one cycle after the accepting edge. Combinational outputs reflect the new pc in the same cycle it is registered.

Decomposition:
- Shared package holds XLEN, RESET_PC default, the state encoding (BOOT=2'd0, RUN=2'd1, TRAP=2'd2), and the instruction width constant 4.
- One sub-module is natural: pc_adder, an XLEN-bit adder used twice (pc+4, pc+offset_shl).
- FSM, PC register, trap capture and instret counter stay in the top.

Test Plan:
- Reset then run: reset 1 cycle, fetch_ready=1, branch=0 → fetch_valid=0 for BOOT cycle; pc sequence then 0, 4, 8, 12; instret=3 after 3 advances.
- Taken branch: pc=0x100, branch=1, zero=1, offset_shl=0x20 → next pc=0x120, instret increments. Same with zero=0 → pc=0x104.
- Stall / not ready: pc=0x40 with stall=1 for 3 cycles, then fetch_ready=0 for 2 cycles → pc stays 0x40, instret unchanged. Release both → pc=0x44.
- Negative offset and wrap:
  - pc=0x10, offset_shl=64'hFFFF_FFFF_FFFF_FFF0, taken → pc=0.
  - pc=64'hFFFF_FFFF_FFFF_FFFC, not taken → pc=0.
- Misaligned trap: pc=0x200, offset_shl=0x6, taken, stall=0 → trap=1, trap_addr=0x206, pc stays 0x200, fetch_valid=0. Inputs toggled for 5 cycles cause no change.
- Reset from TRAP and with stall: assert reset while in TRAP with stall=1 → next cycle pc=RESET_PC, trap=0, trap_addr=0, instret=0, state BOOT.
